// File: rtl/ula_74181.sv
// ula_74181: registered 4-bit ALU implementing the 74181 function set with
// active-high data. Sixteen logic functions (m=1) and sixteen arithmetic
// functions (m=0) are selected by s; all results are captured on rising clk.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst_n  - asynchronous active-low reset, clears all outputs immediately
//   a, b   - 4-bit operands
//   s      - function select S3..S0
//   m      - mode: 0 = arithmetic, 1 = logic
//   c_in   - carry-in, active-high (adds one in arithmetic mode)
//   f      - registered result
//   a_eq_b - registered flag, set when the result is all ones
//   c_out  - registered carry-out, active-high (0 in logic mode)
module ula_74181 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       a_eq_b,
    output logic       c_out
);

    localparam int unsigned W = 4;

    logic [W-1:0] x_c;
    logic [W-1:0] y_c;
    logic [W:0]   carry_c;
    logic [W-1:0] f_d;
    logic         c_out_d;
    logic         a_eq_b_d;
    logic [W-1:0] f_q;
    logic         c_out_q;
    logic         a_eq_b_q;

    // Per-bit function terms. Y is always a subset of X (both contain a),
    // so X acts as the propagate term and Y as the generate term of X+Y.
    always_comb begin
        x_c = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        y_c = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    end

    // Flat carry-lookahead over the four bits: c[i+1] = Y[i] | X[i]&c[i].
    always_comb begin
        carry_c    = '0;
        carry_c[0] = c_in;
        carry_c[1] = y_c[0]
                   | (x_c[0] & c_in);
        carry_c[2] = y_c[1]
                   | (x_c[1] & y_c[0])
                   | (x_c[1] & x_c[0] & c_in);
        carry_c[3] = y_c[2]
                   | (x_c[2] & y_c[1])
                   | (x_c[2] & x_c[1] & y_c[0])
                   | (x_c[2] & x_c[1] & x_c[0] & c_in);
        carry_c[4] = y_c[3]
                   | (x_c[3] & y_c[2])
                   | (x_c[3] & x_c[2] & y_c[1])
                   | (x_c[3] & x_c[2] & x_c[1] & y_c[0])
                   | (x_c[3] & x_c[2] & x_c[1] & x_c[0] & c_in);
    end

    // Logic mode behaves like every internal carry forced high, which turns
    // the sum bit X^Y^c into ~(X^Y) and ignores c_in.
    always_comb begin
        f_d      = '0;
        c_out_d  = 1'b0;
        a_eq_b_d = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            f_d[i] = x_c[i] ^ y_c[i] ^ (m | carry_c[i]);
        end
        c_out_d  = ~m & carry_c[W];
        a_eq_b_d = &f_d;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
        end else begin
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
        end
    end

    assign f      = f_q;
    assign c_out  = c_out_q;
    assign a_eq_b = a_eq_b_q;

endmodule

// File: tb/tb_ula_74181.sv
// Testbench for ula_74181: directed vectors with hand-computed results.
// Stimulus pushes expected outputs into a queue at the falling edge; a
// monitor pops and compares one entry just after each rising edge.
module tb_ula_74181;

    typedef struct {
        logic [3:0] f;
        logic       co;
        logic       eq;
        string      name;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       a_eq_b;
    logic       c_out;

    exp_t exp_q[$];
    int   n_checks;
    int   n_passed;

    ula_74181 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .f      (f),
        .a_eq_b (a_eq_b),
        .c_out  (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] ef,
                         input logic eco, input logic eeq);
        n_checks++;
        if (f === ef && c_out === eco && a_eq_b === eeq) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got f=%b c_out=%b a_eq_b=%b, expected f=%b c_out=%b a_eq_b=%b",
                     name, f, c_out, a_eq_b, ef, eco, eeq);
        end
    endtask

    // Drive one vector at the falling edge and record its expected result.
    task automatic apply(input logic mm, input logic [3:0] ss, input logic [3:0] aa,
                         input logic [3:0] bb, input logic cc, input logic [3:0] ef,
                         input logic eco, input logic eeq, input string name);
        exp_t e;
        @(negedge clk);
        m    = mm;
        s    = ss;
        a    = aa;
        b    = bb;
        c_in = cc;
        e.f    = ef;
        e.co   = eco;
        e.eq   = eeq;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, e.f, e.co, e.eq);
            end
        end
    end

    initial begin
        logic [15:0] arith_ones;
        logic [15:0] logic_ones;
        int          waited;
        exp_t        e;

        n_checks = 0;
        n_passed = 0;
        rst_n = 1'b0;
        a = 4'b1111; b = 4'b1111; s = 4'b1001; m = 1'b0; c_in = 1'b1;

        // Reset holds outputs at zero even across a rising edge.
        #3;
        check("reset_initial", 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply(1'b0, 4'b1001, 4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b1, "add_a_plus_b");
        apply(1'b0, 4'b1001, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b1, "add_max_cin");
        apply(1'b0, 4'b0110, 4'b0110, 4'b1001, 1'b1, 4'b1101, 1'b0, 1'b0, "sub_borrow");
        apply(1'b0, 4'b0110, 4'b1001, 4'b0110, 1'b1, 4'b0011, 1'b1, 1'b0, "sub_no_borrow");
        apply(1'b0, 4'b0110, 4'b0111, 4'b0111, 1'b0, 4'b1111, 1'b0, 1'b1, "a_equals_b");
        apply(1'b0, 4'b1100, 4'b1100, 4'b0011, 1'b0, 4'b1000, 1'b1, 1'b0, "double_a_wrap");
        apply(1'b1, 4'b0110, 4'b1100, 4'b0011, 1'b0, 4'b1111, 1'b0, 1'b1, "logic_xor_ones");
        apply(1'b1, 4'b0110, 4'b0011, 4'b0101, 1'b1, 4'b0110, 1'b0, 1'b0, "logic_xor_cin_ignored");
        apply(1'b1, 4'b1011, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, "logic_and");
        apply(1'b0, 4'b1111, 4'b0101, 4'b0011, 1'b0, 4'b0100, 1'b1, 1'b0, "a_minus_1");
        apply(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b1, "zero_minus_1");

        // All-zero operand sweep; masks list which selects give 1111.
        arith_ones = 16'hCCCC;
        logic_ones = 16'h3333;
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 4'(i), 4'b0000, 4'b0000, 1'b0,
                  arith_ones[i] ? 4'b1111 : 4'b0000, 1'b0, arith_ones[i],
                  $sformatf("sweep_arith_s%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 4'(i), 4'b0000, 4'b0000, 1'b0,
                  logic_ones[i] ? 4'b1111 : 4'b0000, 1'b0, logic_ones[i],
                  $sformatf("sweep_logic_s%0d", i));
        end

        // Leave a nonzero result registered, then reset between edges.
        apply(1'b0, 4'b1001, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b1, "pre_reset_value");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m = 1'b0; s = 4'b1001; a = 4'b0011; b = 4'b0100; c_in = 1'b1;
        #1;
        check("after_release_no_edge", 4'b0000, 1'b0, 1'b0);
        e.f = 4'b1000; e.co = 1'b0; e.eq = 1'b0; e.name = "first_capture_after_reset";
        exp_q.push_back(e);

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
